// File: rtl/fp_align_pipe_pkg.sv
// Shared widths, bit positions and payload types for the FP add/sub alignment stage.
package fp_align_pipe_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned SIG_W = MAN_W + 4;

  // Positions of the rounding bits inside an extended significand.
  localparam int unsigned GUARD  = 2;
  localparam int unsigned ROUND  = 1;
  localparam int unsigned STICKY = 0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } unpacked_fp_t;

  typedef struct packed {
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] big_sig;
    logic [SIG_W-1:0] small_sig;
    logic             swapped;
    logic             eff_sub;
  } aligned_t;

endpackage

// File: rtl/fp_align_pipe_sticky_shift.sv
// Right shift of an extended significand with sticky collection and saturation.
module sticky_shift
  import fp_align_pipe_pkg::*;
#(
  parameter int unsigned SIG_W = 27,
  parameter int unsigned EXP_W = 8
) (
  input  logic [SIG_W-1:0] ext,
  input  logic [EXP_W-1:0] diff,
  output logic [SIG_W-1:0] small_sig_c
);

  localparam int unsigned CMP_W = 32;

  logic [SIG_W-1:0] lost;

  // Shift, fold every discarded bit into the sticky position, saturate past full width.
  always_comb begin
    lost        = '0;
    small_sig_c = ext;
    if (diff == '0) begin
      small_sig_c = ext;
    end else if (CMP_W'(diff) >= CMP_W'(SIG_W)) begin
      small_sig_c = {{(SIG_W-1){1'b0}}, |ext};
    end else begin
      lost                = ext & ~({SIG_W{1'b1}} << diff);
      small_sig_c         = ext >> diff;
      small_sig_c[STICKY] = small_sig_c[STICKY] | (|lost);
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage compare/swap + align pipeline feeding the significand adder.
module fp_align_pipe
  import fp_align_pipe_pkg::*;
#(
  parameter int unsigned EXP_W = fp_align_pipe_pkg::EXP_W,
  parameter int unsigned MAN_W = fp_align_pipe_pkg::MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 a_sign,
  input  logic                 b_sign,
  input  logic [EXP_W-1:0]     a_exp,
  input  logic [EXP_W-1:0]     b_exp,
  input  logic [MAN_W-1:0]     a_man,
  input  logic [MAN_W-1:0]     b_man,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 big_sign,
  output logic                 small_sign,
  output logic [EXP_W-1:0]     exp_out,
  output logic [MAN_W+3:0]     big_sig,
  output logic [MAN_W+3:0]     small_sig,
  output logic                 swapped,
  output logic                 eff_sub
);

  localparam int unsigned SIG_W = MAN_W + 4;

  // Stage 1 holding registers
  logic             s1_valid;
  logic             s1_big_sign;
  logic             s1_small_sign;
  logic [EXP_W-1:0] s1_big_exp;
  logic [MAN_W-1:0] s1_big_man;
  logic [EXP_W-1:0] s1_small_exp;
  logic [MAN_W-1:0] s1_small_man;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_swapped;

  logic             s1_adv_c;
  logic             in_fire_c;
  logic             swap_c;
  logic [SIG_W-1:0] small_ext_c;
  logic [SIG_W-1:0] shifted_c;

  // Handshake: each stage moves when it holds data and the slot ahead is free or draining.
  always_comb begin
    s1_adv_c  = s1_valid && (!out_valid || out_ready);
    in_ready  = !s1_valid || s1_adv_c;
    in_fire_c = in_valid && in_ready;
  end

  // b becomes big on a larger exponent, or equal exponent with a larger fraction.
  always_comb begin
    swap_c = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
  end

  // Stage 1: register big/small operands and the unsigned exponent difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_big_sign   <= 1'b0;
      s1_small_sign <= 1'b0;
      s1_big_exp    <= '0;
      s1_big_man    <= '0;
      s1_small_exp  <= '0;
      s1_small_man  <= '0;
      s1_diff       <= '0;
      s1_swapped    <= 1'b0;
    end else begin
      if (in_fire_c) begin
        s1_valid   <= 1'b1;
        s1_swapped <= swap_c;
        if (swap_c) begin
          s1_big_sign   <= b_sign;
          s1_big_exp    <= b_exp;
          s1_big_man    <= b_man;
          s1_small_sign <= a_sign;
          s1_small_exp  <= a_exp;
          s1_small_man  <= a_man;
          s1_diff       <= b_exp - a_exp;
        end else begin
          s1_big_sign   <= a_sign;
          s1_big_exp    <= a_exp;
          s1_big_man    <= a_man;
          s1_small_sign <= b_sign;
          s1_small_exp  <= b_exp;
          s1_small_man  <= b_man;
          s1_diff       <= a_exp - b_exp;
        end
      end else if (s1_adv_c) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Hidden bit is set for any non-zero exponent; denormals keep their own exponent.
  always_comb begin
    small_ext_c = {(s1_small_exp != '0), s1_small_man, 3'b000};
  end

  sticky_shift #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W)
  ) u_sticky_shift (
    .ext         (small_ext_c),
    .diff        (s1_diff),
    .small_sig_c (shifted_c)
  );

  // Stage 2: register aligned result; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      exp_out    <= '0;
      big_sig    <= '0;
      small_sig  <= '0;
      swapped    <= 1'b0;
      eff_sub    <= 1'b0;
    end else begin
      if (s1_adv_c) begin
        out_valid  <= 1'b1;
        big_sign   <= s1_big_sign;
        small_sign <= s1_small_sign;
        exp_out    <= s1_big_exp;
        big_sig    <= {(s1_big_exp != '0), s1_big_man, 3'b000};
        small_sig  <= shifted_c;
        swapped    <= s1_swapped;
        eff_sub    <= s1_big_sign ^ s1_small_sign;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe: directed vectors, stalled stream, mid-stream reset.
module tb_fp_align_pipe;
  import fp_align_pipe_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             out_valid;
  logic             out_ready;
  logic             big_sign, small_sign;
  logic [EXP_W-1:0] exp_out;
  logic [SIG_W-1:0] big_sig, small_sig;
  logic             swapped, eff_sub;

  int       tests = 0;
  int       fails = 0;
  int       pops  = 0;
  aligned_t q[$];
  logic     held = 1'b0;
  aligned_t snap;

  fp_align_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_sign     (a_sign),
    .b_sign     (b_sign),
    .a_exp      (a_exp),
    .b_exp      (b_exp),
    .a_man      (a_man),
    .b_man      (b_man),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_sign   (big_sign),
    .small_sign (small_sign),
    .exp_out    (exp_out),
    .big_sig    (big_sig),
    .small_sig  (small_sig),
    .swapped    (swapped),
    .eff_sub    (eff_sub)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic aligned_t dut_res();
    aligned_t r;
    r = {big_sign, small_sign, exp_out, big_sig, small_sig, swapped, eff_sub};
    return r;
  endfunction

  // Reference: bit-serial shift with sticky accumulation.
  function automatic aligned_t model(input logic as, input logic [EXP_W-1:0] ae, input logic [MAN_W-1:0] am,
                                     input logic bs, input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] bm);
    aligned_t         r;
    logic             sw, st;
    logic [EXP_W-1:0] se, d;
    logic [MAN_W-1:0] sm;
    logic [SIG_W-1:0] v;
    sw = (be > ae) || (be == ae && bm > am);
    r.swapped    = sw;
    r.big_sign   = sw ? bs : as;
    r.small_sign = sw ? as : bs;
    r.exp        = sw ? be : ae;
    se           = sw ? ae : be;
    sm           = sw ? am : bm;
    r.big_sig    = {(r.exp != 0), (sw ? bm : am), 3'b000};
    d            = r.exp - se;
    v            = {(se != 0), sm, 3'b000};
    st           = 1'b0;
    for (int i = 0; i < int'(d); i++) begin
      st = st | v[0];
      v  = v >> 1;
    end
    v[0]        = v[0] | st;
    r.small_sig = v;
    r.eff_sub   = r.big_sign ^ r.small_sign;
    return r;
  endfunction

  // One clock: check hold/ready, pop on output transfer, push on input transfer.
  task automatic tick(output logic acc);
    aligned_t e;
    #1;
    if (held) chk("stall_hold", {out_valid, dut_res()}, {1'b1, snap});
    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
    if (out_valid && out_ready) begin
      pops++;
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", dut_res(), e);
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(a_sign, a_exp, a_man, b_sign, b_exp, b_man));
    held = out_valid && !out_ready;
    snap = dut_res();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic as, input int ae, input int am, input logic bs, input int be, input int bm);
    a_sign = as; a_exp = EXP_W'(ae); a_man = MAN_W'(am);
    b_sign = bs; b_exp = EXP_W'(be); b_man = MAN_W'(bm);
  endtask

  // Single pair: check 2-cycle latency and the literal expected fields.
  task automatic directed(input string tag, input logic as, input int ae, input int am,
                          input logic bs, input int be, input int bm,
                          input int x_exp, input int x_big, input int x_small, input logic x_sw, input logic x_sub);
    logic acc;
    out_ready = 1'b1;
    set_in(as, ae, am, bs, be, bm);
    in_valid = 1'b1;
    tick(acc);
    chk({tag, "_accept"}, acc, 1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick(acc);
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_exp"}, exp_out, x_exp);
    chk({tag, "_big"}, big_sig, x_big);
    chk({tag, "_small"}, small_sig, x_small);
    chk({tag, "_sw_sub"}, {swapped, eff_sub}, {x_sw, x_sub});
    tick(acc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   sent, cyc, pops0;
    int   sa_e[8], sa_m[8], sb_e[8], sb_m[8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", dut_res(), 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    directed("equal",   0, 127, 0,        0, 127, 0, 127, 'h4000000, 'h4000000, 0, 0);
    directed("swap",    0, 127, 'h400000, 1, 130, 0, 130, 'h4000000, 'h0C00000, 1, 1);
    directed("diff24",  0, 151, 0,        0, 127, 1, 151, 'h4000000, 'h0000005, 0, 0);
    directed("diff30",  0, 157, 0,        0, 127, 1, 157, 'h4000000, 'h0000001, 0, 0);
    directed("man_tie", 1, 100, 5,        0, 100, 9, 100, {1'b1, 23'd9, 3'b000}, {1'b1, 23'd5, 3'b000}, 1, 1);

    // Stream of 8 pairs under a 1,0,0 out_ready pattern.
    for (int i = 0; i < 8; i++) begin
      sa_e[i] = int'($urandom_range(0, 180));
      sb_e[i] = int'($urandom_range(0, 180));
      sa_m[i] = int'($urandom_range(0, 32'h7FFFFF));
      sb_m[i] = int'($urandom_range(0, 32'h7FFFFF));
    end
    sb_e[3] = sa_e[3];
    sent = 0; cyc = 0; pops0 = pops;
    while ((sent < 8 || q.size() != 0) && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) set_in(sent[0], sa_e[sent], sa_m[sent], ~sent[1], sb_e[sent], sb_m[sent]);
      tick(acc);
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_drained", q.size(), 0);
    chk("stream_count", pops - pops0, 8);

    // Two pairs in flight, then an asynchronous reset between edges.
    out_ready = 1'b0;
    set_in(0, 140, 3, 0, 120, 7);
    in_valid = 1'b1;
    tick(acc);
    set_in(1, 90, 11, 0, 95, 2);
    tick(acc);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", dut_res(), 0);
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed("post_rst", 0, 127, 'h400000, 1, 130, 0, 130, 'h4000000, 'h0C00000, 1, 1);
    chk("final_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Pipelined, parametrised significand-alignment stage for the FP add/sub datapath.
- Accepts two unpacked operands (sign, biased exponent, fraction) and compares exponents. Swaps so the larger-magnitude-exponent operand is "big".
- Right-shifts the small operand's extended significand by the exponent difference, generating guard/round/sticky bits and saturating on large shifts.
- Two-stage valid/ready pipeline feeding the significand adder.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; extended significand width SIG_W = MAN_W+4 (hidden, fraction, G, R, S)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept pair this cycle
- a_sign, b_sign  in  1  operand signs
- a_exp, b_exp  in  EXP_W  biased exponents
- a_man, b_man  in  MAN_W  fractions
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- big_sign, small_sign  out  1  signs after swap
- exp_out  out  EXP_W  larger exponent
- big_sig  out  SIG_W  {hidden, big fraction, 3'b000}
- small_sig  out  SIG_W  aligned small significand incl. G/R/S
- swapped  out  1  1 when b was selected as big
- eff_sub  out  1  big_sign ^ small_sign

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst): all valid flags clear immediately; all data registers clear to 0; out_valid=0, all outputs 0.
- Hidden bit = 1 if exponent != 0, else 0 (denormals treated with their own exponent; no exponent-of-1 adjustment in this block).
- Stage 1 (compare/swap):
  - Swap when b_exp > a_exp, or when exponents are equal and b_man > a_man. Otherwise a is big; ties keep a.
  - Register big/small fields, diff = big_exp - small_exp (EXP_W bits, unsigned, never negative), and s1_valid.
- Stage 2 (shift):
  - ext = {hidden, man, 3'b000}.
  - diff == 0: small_sig = ext.
  - 0 < diff < SIG_W: small_sig = (ext >> diff), with bit0 ORed with the OR of all bits shifted out (sticky).
  - diff >= SIG_W: small_sig = {SIG_W-1 zeros, |ext}.
  - Registers outputs and out_valid.
- Handshake:
  - Stage k advances when it holds data and the next slot is empty or draining this cycle.
  - in_ready = !s1_valid || (s1 advances this cycle). Combinational from out_ready through both stages; no bubbles under continuous flow.
  - Transfer at the input occurs on in_valid && in_ready.
  - Output data must hold stable while out_valid && !out_ready.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput is one pair per cycle.
- Simultaneous: s2 draining and s1 refilling in the same cycle is legal and loses nothing.
- Reset mid-stream discards all in-flight data; the first post-reset accept behaves identically to a cold start.
- NaN/Inf are not special-cased here; exponent all-ones is passed through arithmetically.

Decomposition:
- addpkg gains:
  - localparams GUARD=2, ROUND=1, STICKY=0
  - typedef unpacked_fp_t {sign, exp, man} parametrised via package constants EXP_W/MAN_W for the default single-precision build
  - typedef aligned_t for the stage-2 payload
- One sub-module: sticky_shift (combinational, parametrised SIG_W/EXP_W) implementing the shift/sticky/saturation rule; instantiated in stage 2 and reusable by the normaliser.

Test Plan (defaults, single precision):
- a=(0,127,0), b=(0,127,0) -> after 2 cycles: exp_out=127, big_sig=small_sig=27'h4000000, swapped=0, eff_sub=0.
- a=(0,127,0x400000), b=(1,130,0) -> swapped=1, exp_out=130, big_sig=27'h4000000, small_sig=27'h0C00000, eff_sub=1.
- a=(0,151,0), b=(0,127,0x000001), diff 24 -> small_sig=27'h0000005 (guard set, sticky set).
- a=(0,157,0), b=(0,127,0x000001), diff 30 -> saturation, small_sig=27'h0000001.
- Stream 8 back-to-back pairs with out_ready toggled 1,0,0,1,... -> results in order, none dropped or duplicated, outputs stable during stall, in_ready deasserts when both stages are full.
- Assert rst for 1 cycle with 2 pairs in flight -> out_valid falls asynchronously to 0; next accepted pair emerges exactly 2 cycles later with correct values.
